// File: rtl/ctrl_pipe_stage.sv
// ID/EX control register: opcode decode, load-use bubbles, flush bubbles,
// data-cache stall freeze and saturating bubble/stall performance counters.
module ctrl_pipe_stage #(
  parameter int unsigned OP_W   = 7,
  parameter int unsigned RA_W   = 5,
  parameter int unsigned EXT_EN = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic [OP_W-1:0]  Op_i,
  input  logic [RA_W-1:0]  rs1_i,
  input  logic [RA_W-1:0]  rs2_i,
  input  logic [RA_W-1:0]  rd_i,
  input  logic             mem_stall_i,
  input  logic             flush_i,
  output logic             RegWrite_o,
  output logic             MemtoReg_o,
  output logic             MemRead_o,
  output logic             MemWrite_o,
  output logic             ALUSrc_o,
  output logic             Branch_o,
  output logic             Jump_o,
  output logic [1:0]       ALUOp_o,
  output logic [RA_W-1:0]  rd_o,
  output logic             valid_o,
  output logic             stall_o,
  output logic [CNT_W-1:0] bubble_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [OP_W-1:0] OP_R    = OP_W'(7'b0110011);
  localparam logic [OP_W-1:0] OP_I    = OP_W'(7'b0010011);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'(7'b0000011);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'(7'b0100011);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'(7'b1100011);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'(7'b1101111);
  localparam logic [OP_W-1:0] OP_JALR = OP_W'(7'b1100111);
  localparam logic [OP_W-1:0] OP_LUI  = OP_W'(7'b0110111);

  // Field order follows the decode table: ALUOp, ALUSrc, RegWrite, MemtoReg,
  // MemRead, MemWrite, Branch, Jump.
  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       jump;
  } ctrl_t;

  typedef enum logic {ST_RUN, ST_MWAIT} state_t;

  state_t            state_q, state_d;
  logic              pend_q, pend_d;
  ctrl_t             ex_q, ex_d;
  logic [RA_W-1:0]   rd_q, rd_d;
  logic              valid_q, valid_d;
  logic [CNT_W-1:0]  bub_cnt_q, bub_cnt_d;
  logic [CNT_W-1:0]  stl_cnt_q, stl_cnt_d;

  ctrl_t             dec_ctrl;
  logic              dec_known;
  logic              use_rs1;
  logic              use_rs2;
  logic              hazard;
  logic              flush_eff;
  logic              stall_c;
  logic              bub_inc;
  logic              stl_inc;

  // Opcode decode; an empty ID slot decodes like an unknown opcode.
  always_comb begin
    dec_ctrl  = '0;
    dec_known = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    case (Op_i)
      OP_R:   begin dec_ctrl = ctrl_t'(9'b10_0100000); dec_known = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_I:   begin dec_ctrl = ctrl_t'(9'b11_1100000); dec_known = 1'b1; use_rs1 = 1'b1; end
      OP_LW:  begin dec_ctrl = ctrl_t'(9'b00_1111000); dec_known = 1'b1; use_rs1 = 1'b1; end
      OP_SW:  begin dec_ctrl = ctrl_t'(9'b00_1000100); dec_known = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_BEQ: begin dec_ctrl = ctrl_t'(9'b01_0000010); dec_known = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OP_JAL: begin
        if (EXT_EN != 0) begin dec_ctrl = ctrl_t'(9'b00_0100001); dec_known = 1'b1; end
      end
      OP_JALR: begin
        if (EXT_EN != 0) begin dec_ctrl = ctrl_t'(9'b00_1100001); dec_known = 1'b1; use_rs1 = 1'b1; end
      end
      OP_LUI: begin
        if (EXT_EN != 0) begin dec_ctrl = ctrl_t'(9'b11_1100000); dec_known = 1'b1; end
      end
      default: ;
    endcase
    if (!valid_i) begin
      dec_ctrl  = '0;
      dec_known = 1'b0;
      use_rs1   = 1'b0;
      use_rs2   = 1'b0;
    end
  end

  assign hazard = valid_q && ex_q.mem_read && (rd_q != '0) && dec_known &&
                  ((use_rs1 && (rs1_i == rd_q)) || (use_rs2 && (rs2_i == rd_q)));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state_q <= ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (mem_stall_i)  state_d = ST_MWAIT;
      ST_MWAIT: if (!mem_stall_i) state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  // EX-register update, stall request and counter increments.
  always_comb begin
    ex_d      = ex_q;
    rd_d      = rd_q;
    valid_d   = valid_q;
    pend_d    = pend_q;
    stall_c   = 1'b0;
    bub_inc   = 1'b0;
    stl_inc   = 1'b0;
    flush_eff = flush_i || ((state_q == ST_MWAIT) && pend_q);
    if (mem_stall_i) begin
      stall_c = 1'b1;
      if (state_q == ST_RUN) begin
        pend_d = flush_i;
      end else begin
        pend_d  = pend_q || flush_i;
        stl_inc = 1'b1;
      end
    end else begin
      pend_d  = 1'b0;
      stl_inc = (state_q == ST_MWAIT);
      if (flush_eff || hazard) begin
        ex_d    = '0;
        rd_d    = '0;
        valid_d = 1'b0;
        bub_inc = 1'b1;
        stall_c = !flush_eff;
      end else begin
        ex_d    = dec_ctrl;
        rd_d    = dec_known ? rd_i : '0;
        valid_d = dec_known;
      end
    end
  end

  assign bub_cnt_d = (bub_inc && (bub_cnt_q != '1)) ? bub_cnt_q + CNT_W'(1) : bub_cnt_q;
  assign stl_cnt_d = (stl_inc && (stl_cnt_q != '1)) ? stl_cnt_q + CNT_W'(1) : stl_cnt_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      pend_q    <= 1'b0;
      ex_q      <= '0;
      rd_q      <= '0;
      valid_q   <= 1'b0;
      bub_cnt_q <= '0;
      stl_cnt_q <= '0;
    end else begin
      pend_q    <= pend_d;
      ex_q      <= ex_d;
      rd_q      <= rd_d;
      valid_q   <= valid_d;
      bub_cnt_q <= bub_cnt_d;
      stl_cnt_q <= stl_cnt_d;
    end
  end

  // Stall request is masked while reset is held.
  assign stall_o      = rst_i && stall_c;
  assign RegWrite_o   = ex_q.reg_write;
  assign MemtoReg_o   = ex_q.mem_to_reg;
  assign MemRead_o    = ex_q.mem_read;
  assign MemWrite_o   = ex_q.mem_write;
  assign ALUSrc_o     = ex_q.alu_src;
  assign Branch_o     = ex_q.branch;
  assign Jump_o       = ex_q.jump;
  assign ALUOp_o      = ex_q.alu_op;
  assign rd_o         = rd_q;
  assign valid_o      = valid_q;
  assign bubble_cnt_o = bub_cnt_q;
  assign stall_cnt_o  = stl_cnt_q;

endmodule

// File: tb/tb_ctrl_pipe_stage.sv
// Bench for ctrl_pipe_stage: two instances (EXT_EN=1/CNT_W=16, EXT_EN=0/CNT_W=2)
// driven in lockstep and checked against a table-driven pipeline model.
module tb_ctrl_pipe_stage;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_JALR= 7'b1100111;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_BAD = 7'b1111111;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       valid_i;
  logic [6:0] Op_i;
  logic [4:0] rs1_i, rs2_i, rd_i;
  logic       mem_stall_i, flush_i;

  logic [1:0] regw, m2r, mrd, mwr, alusrc, br, jmp, vo, stl;
  logic [1:0] aluop [2];
  logic [4:0] rdo   [2];
  logic [15:0] bcnt0, scnt0;
  logic [1:0]  bcnt1, scnt1;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk_i = ~clk_i;

  ctrl_pipe_stage #(.OP_W(7), .RA_W(5), .EXT_EN(1), .CNT_W(16)) u_dut0 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .Op_i(Op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .mem_stall_i(mem_stall_i), .flush_i(flush_i),
    .RegWrite_o(regw[0]), .MemtoReg_o(m2r[0]), .MemRead_o(mrd[0]), .MemWrite_o(mwr[0]),
    .ALUSrc_o(alusrc[0]), .Branch_o(br[0]), .Jump_o(jmp[0]), .ALUOp_o(aluop[0]),
    .rd_o(rdo[0]), .valid_o(vo[0]), .stall_o(stl[0]),
    .bubble_cnt_o(bcnt0), .stall_cnt_o(scnt0));

  ctrl_pipe_stage #(.OP_W(7), .RA_W(5), .EXT_EN(0), .CNT_W(2)) u_dut1 (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .Op_i(Op_i),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .mem_stall_i(mem_stall_i), .flush_i(flush_i),
    .RegWrite_o(regw[1]), .MemtoReg_o(m2r[1]), .MemRead_o(mrd[1]), .MemWrite_o(mwr[1]),
    .ALUSrc_o(alusrc[1]), .Branch_o(br[1]), .Jump_o(jmp[1]), .ALUOp_o(aluop[1]),
    .rd_o(rdo[1]), .valid_o(vo[1]), .stall_o(stl[1]),
    .bubble_cnt_o(bcnt1), .stall_cnt_o(scnt1));

  // Model state per instance: EX slot {ctrl, rd, valid}, wait flag, remembered flush, counters.
  logic [8:0]  m_ctrl [2], n_ctrl [2];
  logic [4:0]  m_rd   [2], n_rd   [2];
  bit          m_valid[2], n_valid[2];
  bit          m_wait [2], n_wait [2];
  bit          m_pend [2], n_pend [2];
  int unsigned m_bub  [2], n_bub  [2];
  int unsigned m_stl  [2], n_stl  [2];
  bit          e_stall[2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // {use_rs1, use_rs2, known, ALUOp, ALUSrc, RegWrite, MemtoReg, MemRead, MemWrite, Branch, Jump}
  function automatic logic [11:0] dec(input logic [6:0] op, input bit ext);
    case (op)
      OP_R:    return {3'b111, 9'b10_0_1_0_0_0_0_0};
      OP_I:    return {3'b101, 9'b11_1_1_0_0_0_0_0};
      OP_LW:   return {3'b101, 9'b00_1_1_1_1_0_0_0};
      OP_SW:   return {3'b111, 9'b00_1_0_0_0_1_0_0};
      OP_BEQ:  return {3'b111, 9'b01_0_0_0_0_0_1_0};
      OP_JAL:  return ext ? {3'b001, 9'b00_0_1_0_0_0_0_1} : 12'd0;
      OP_JALR: return ext ? {3'b101, 9'b00_1_1_0_0_0_0_1} : 12'd0;
      OP_LUI:  return ext ? {3'b001, 9'b11_1_1_0_0_0_0_0} : 12'd0;
      default: return 12'd0;
    endcase
  endfunction

  function automatic int unsigned sat_inc(input int unsigned x, input int k);
    int unsigned mx;
    mx = (k == 0) ? 32'd65535 : 32'd3;
    return (x >= mx) ? mx : x + 1;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ctrl[k] = '0; m_rd[k] = '0; m_valid[k] = 0; m_wait[k] = 0;
      m_pend[k] = 0;  m_bub[k] = 0; m_stl[k] = 0;
    end
  endtask

  // Compute the expected stall request and the EX/counter contents after the next edge.
  task automatic model_comb(input int k);
    logic [11:0] d;
    bit kn, haz, fl;
    d  = dec(Op_i, k == 0);
    kn = valid_i && d[9];
    haz = m_valid[k] && m_ctrl[k][3] && (m_rd[k] != 0) && kn &&
          ((d[11] && rs1_i == m_rd[k]) || (d[10] && rs2_i == m_rd[k]));
    n_ctrl[k] = m_ctrl[k]; n_rd[k] = m_rd[k]; n_valid[k] = m_valid[k];
    n_wait[k] = m_wait[k]; n_pend[k] = m_pend[k]; n_bub[k] = m_bub[k]; n_stl[k] = m_stl[k];
    if (mem_stall_i) begin
      e_stall[k] = 1;
      n_wait[k]  = 1;
      if (!m_wait[k]) n_pend[k] = flush_i;
      else begin
        n_pend[k] = m_pend[k] | flush_i;
        n_stl[k]  = sat_inc(m_stl[k], k);
      end
    end else begin
      fl = flush_i || (m_wait[k] && m_pend[k]);
      if (m_wait[k]) n_stl[k] = sat_inc(m_stl[k], k);
      n_wait[k] = 0; n_pend[k] = 0;
      e_stall[k] = !fl && haz;
      if (fl || haz) begin
        n_ctrl[k] = '0; n_rd[k] = '0; n_valid[k] = 0;
        n_bub[k] = sat_inc(m_bub[k], k);
      end else begin
        n_ctrl[k]  = kn ? d[8:0] : 9'd0;
        n_rd[k]    = kn ? rd_i : 5'd0;
        n_valid[k] = kn;
      end
    end
  endtask

  task automatic check_outs();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ex%0d", k),
          32'({aluop[k], alusrc[k], regw[k], m2r[k], mrd[k], mwr[k], br[k], jmp[k], rdo[k], vo[k]}),
          32'({m_ctrl[k], m_rd[k], m_valid[k]}));
    end
    chk("bcnt0", 32'(bcnt0), m_bub[0]);
    chk("scnt0", 32'(scnt0), m_stl[0]);
    chk("bcnt1", 32'(bcnt1), m_bub[1]);
    chk("scnt1", 32'(scnt1), m_stl[1]);
  endtask

  // Called at posedge+1: check stall request, take the edge, check registered state.
  task automatic step();
    #1;
    for (int k = 0; k < 2; k++) begin
      model_comb(k);
      chk($sformatf("stall%0d", k), 32'(stl[k]), 32'(e_stall[k]));
    end
    @(posedge clk_i);
    #1;
    for (int k = 0; k < 2; k++) begin
      m_ctrl[k] = n_ctrl[k]; m_rd[k] = n_rd[k]; m_valid[k] = n_valid[k];
      m_wait[k] = n_wait[k]; m_pend[k] = n_pend[k]; m_bub[k] = n_bub[k]; m_stl[k] = n_stl[k];
    end
    check_outs();
  endtask

  task automatic cycle(input bit v, input logic [6:0] op, input logic [4:0] r1, input logic [4:0] r2,
                       input logic [4:0] rd, input bit ms, input bit fl);
    valid_i = v; Op_i = op; rs1_i = r1; rs2_i = r2; rd_i = rd;
    mem_stall_i = ms; flush_i = fl;
    step();
  endtask

  logic [6:0] op_tab [10];

  initial begin
    op_tab = '{OP_R, OP_I, OP_LW, OP_LW, OP_SW, OP_BEQ, OP_JAL, OP_JALR, OP_LUI, OP_BAD};
    rst_i = 1'b0; valid_i = 1'b1; Op_i = OP_R; rs1_i = '0; rs2_i = '0; rd_i = 5'd1;
    mem_stall_i = 1'b1; flush_i = 1'b0;
    model_reset();
    #2;
    check_outs();
    chk("rst_stall0", 32'(stl[0]), 32'd0);
    chk("rst_stall1", 32'(stl[1]), 32'd0);
    valid_i = 1'b0; mem_stall_i = 1'b0;
    #6 rst_i = 1'b1;
    @(posedge clk_i);
    #1;

    // Plain R-type issue
    cycle(1, OP_R, 0, 0, 3, 0, 0);
    chk("r_aluop", 32'(aluop[0]), 32'd2);
    chk("r_regw", 32'(regw[0]), 32'd1);
    chk("r_rd", 32'(rdo[0]), 32'd3);
    chk("r_valid", 32'(vo[0]), 32'd1);

    // Load-use: one bubble, then the dependent add issues
    cycle(1, OP_LW, 1, 0, 5, 0, 0);
    cycle(1, OP_R, 5, 2, 6, 0, 0);
    chk("lu_bubble", 32'(vo[0]), 32'd0);
    chk("lu_bcnt", 32'(bcnt0), 32'd1);
    cycle(1, OP_R, 5, 2, 6, 0, 0);
    chk("lu_issue", 32'(vo[0]), 32'd1);
    chk("lu_rd", 32'(rdo[0]), 32'd6);

    // Load to x0 never creates a hazard
    cycle(1, OP_LW, 1, 0, 0, 0, 0);
    cycle(1, OP_R, 0, 0, 7, 0, 0);
    chk("x0_issue", 32'(vo[0]), 32'd1);
    chk("x0_bcnt", 32'(bcnt0), 32'd1);

    // Four-cycle cache stall with a store held in EX
    cycle(1, OP_SW, 1, 2, 0, 0, 0);
    repeat (4) cycle(1, OP_R, 1, 2, 8, 1, 0);
    cycle(1, OP_R, 1, 2, 8, 0, 0);
    chk("ms_scnt", 32'(scnt0), 32'd4);
    chk("ms_exit_rd", 32'(rdo[0]), 32'd8);

    // Flush during the stall is remembered and applied on exit
    cycle(1, OP_R, 1, 2, 9, 1, 0);
    cycle(1, OP_R, 1, 2, 9, 1, 1);
    cycle(1, OP_R, 1, 2, 9, 1, 0);
    cycle(1, OP_R, 1, 2, 9, 0, 0);
    chk("pf_bubble", 32'(vo[0]), 32'd0);
    cycle(1, OP_R, 1, 2, 9, 0, 0);
    chk("pf_cleared", 32'(vo[0]), 32'd1);

    // Stall starting together with a flush
    cycle(1, OP_I, 1, 0, 10, 1, 1);
    cycle(1, OP_I, 1, 0, 10, 0, 0);
    cycle(1, OP_I, 1, 0, 10, 0, 0);

    // Flush beats a simultaneous load-use hazard
    cycle(1, OP_LW, 1, 0, 4, 0, 0);
    cycle(1, OP_R, 4, 0, 11, 0, 1);
    chk("fh_stall_low", 32'(vo[0]), 32'd0);

    // Extended opcodes and an unknown opcode
    cycle(1, OP_JAL, 0, 0, 1, 0, 0);
    chk("jal_jump", 32'(jmp[0]), 32'd1);
    chk("jal_regw", 32'(regw[0]), 32'd1);
    chk("jal_noext", 32'(vo[1]), 32'd0);
    cycle(1, OP_JALR, 3, 0, 2, 0, 0);
    cycle(1, OP_LUI, 0, 0, 3, 0, 0);
    cycle(1, OP_BAD, 1, 1, 4, 0, 0);
    cycle(1, OP_BEQ, 1, 2, 0, 0, 0);
    cycle(0, OP_R, 1, 2, 5, 0, 0);

    // Five flush bubbles saturate the 2-bit counter
    repeat (5) cycle(1, OP_R, 1, 2, 6, 0, 1);
    chk("sat_bcnt1", 32'(bcnt1), 32'd3);

    // Asynchronous reset in the middle of a stall with a remembered flush
    cycle(1, OP_R, 1, 2, 6, 1, 1);
    cycle(1, OP_R, 1, 2, 6, 1, 0);
    #2 rst_i = 1'b0;
    #1;
    model_reset();
    check_outs();
    chk("rst_mw_stall0", 32'(stl[0]), 32'd0);
    chk("rst_mw_stall1", 32'(stl[1]), 32'd0);
    #2;
    rst_i = 1'b1; valid_i = 1'b1; Op_i = OP_R; rs1_i = 5'd1; rs2_i = 5'd2; rd_i = 5'd12;
    mem_stall_i = 1'b0; flush_i = 1'b0;
    step();
    chk("rst_pend_gone", 32'(vo[0]), 32'd1);

    // Randomized traffic with small register indices to provoke hazards
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom % 8) != 0, op_tab[$urandom % 10], 5'($urandom % 4), 5'($urandom % 4),
            5'($urandom % 4), ($urandom % 5) == 0, ($urandom % 7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
